// File: rtl/md_pad_if.sv
// Pad-side pins and decoded PCE button levels of the Mega Drive pad scanner.
// The master modport is the scanner; the slave modport is the pad/consumer side.
interface md_pad_if;
  logic [5:0] md_d;
  logic       md_select;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       i;
  logic       ii;
  logic       iii;
  logic       iv;
  logic       v;
  logic       vi;
  logic       select;
  logic       start;
  logic       pad_present;
  logic       six_button;
  logic       frame_done;

  modport master (
    input  md_d,
    output md_select, up, down, left, right, i, ii, iii, iv, v, vi,
           select, start, pad_present, six_button, frame_done
  );

  modport slave (
    output md_d,
    input  md_select, up, down, left, right, i, ii, iii, iv, v, vi,
           select, start, pad_present, six_button, frame_done
  );
endinterface

// File: rtl/md_pad_scanner.sv
// Mega Drive 3/6-button pad scanner: drives the TH handshake, samples each phase
// and commits twelve active-low PCE button levels once per frame.
module md_pad_scanner #(
  parameter int unsigned STEP_CYCLES = 100,
  parameter int unsigned IDLE_CYCLES = 40000
) (
  input  logic     system_clock,
  input  logic     reset_n,
  md_pad_if.master pad
);

  localparam int unsigned MAX_CYCLES = (STEP_CYCLES > IDLE_CYCLES) ? STEP_CYCLES : IDLE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_STEP0, S_STEP1, S_STEP2, S_STEP3, S_STEP4, S_STEP5, S_STEP6, S_STEP7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sync1_q, sync2_q;

  // Shadow register filled during the frame
  logic [5:0] sh_hi_q, sh_hi_d;       // STEP0 pins: C, B, right, left, down, up
  logic [1:0] sh_lo_q, sh_lo_d;       // STEP1 pins: Start, A
  logic [3:0] sh_ext_q, sh_ext_d;     // STEP6 pins: Mode, X, Y, Z
  logic       sh_present_q, sh_present_d;
  logic       sh_six_q, sh_six_d;

  // Committed outputs
  logic       md_select_q, md_select_d;
  logic [3:0] dir_q, dir_d;           // [0] up, [1] down, [2] left, [3] right
  logic [5:0] btn_q, btn_d;           // [0] i .. [5] vi
  logic       select_q, select_d;
  logic       start_q, start_d;
  logic       pad_present_q, pad_present_d;
  logic       six_button_q, six_button_d;
  logic       frame_done_q, frame_done_d;
  logic       step_last;

  // Pin synchronizer
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 6'h3F;
      sync2_q <= 6'h3F;
    end else begin
      sync1_q <= pad.md_d;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sh_hi_q       <= 6'h3F;
      sh_lo_q       <= 2'b11;
      sh_ext_q      <= 4'hF;
      sh_present_q  <= 1'b0;
      sh_six_q      <= 1'b0;
      md_select_q   <= 1'b1;
      dir_q         <= 4'hF;
      btn_q         <= 6'h3F;
      select_q      <= 1'b1;
      start_q       <= 1'b1;
      pad_present_q <= 1'b0;
      six_button_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_hi_q       <= sh_hi_d;
      sh_lo_q       <= sh_lo_d;
      sh_ext_q      <= sh_ext_d;
      sh_present_q  <= sh_present_d;
      sh_six_q      <= sh_six_d;
      md_select_q   <= md_select_d;
      dir_q         <= dir_d;
      btn_q         <= btn_d;
      select_q      <= select_d;
      start_q       <= start_d;
      pad_present_q <= pad_present_d;
      six_button_q  <= six_button_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Sequencing, per-phase capture and end-of-frame commit
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    sh_hi_d       = sh_hi_q;
    sh_lo_d       = sh_lo_q;
    sh_ext_d      = sh_ext_q;
    sh_present_d  = sh_present_q;
    sh_six_d      = sh_six_q;
    dir_d         = dir_q;
    btn_d         = btn_q;
    select_d      = select_q;
    start_d       = start_q;
    pad_present_d = pad_present_q;
    six_button_d  = six_button_q;
    frame_done_d  = 1'b0;
    md_select_d   = 1'b1;

    step_last = (state_q == S_IDLE) ? (cnt_q == CNT_W'(IDLE_CYCLES - 1))
                                    : (cnt_q == CNT_W'(STEP_CYCLES - 1));

    if (step_last) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE:  state_d = S_STEP0;
        S_STEP0: begin
          state_d = S_STEP1;
          sh_hi_d = sync2_q;
        end
        S_STEP1: begin
          state_d      = S_STEP2;
          sh_lo_d      = sync2_q[5:4];
          sh_present_d = (sync2_q[3:2] == 2'b00);
        end
        S_STEP2: state_d = S_STEP3;
        S_STEP3: state_d = S_STEP4;
        S_STEP4: state_d = S_STEP5;
        S_STEP5: begin
          state_d  = S_STEP6;
          sh_six_d = (sync2_q[3:0] == 4'b0000);
        end
        S_STEP6: begin
          state_d  = S_STEP7;
          sh_ext_d = sync2_q[3:0];
        end
        S_STEP7: begin
          state_d       = S_IDLE;
          frame_done_d  = 1'b1;
          pad_present_d = sh_present_q;
          six_button_d  = sh_present_q & sh_six_q;
          dir_d         = 4'hF;
          btn_d         = 6'h3F;
          select_d      = 1'b1;
          start_d       = 1'b1;
          if (sh_present_q) begin
            dir_d    = sh_hi_q[3:0];
            btn_d[0] = sh_hi_q[5];
            btn_d[1] = sh_hi_q[4];
            btn_d[2] = sh_lo_q[0];
            start_d  = sh_lo_q[1];
            if (sh_six_q) begin
              btn_d[3] = sh_ext_q[2];
              btn_d[4] = sh_ext_q[1];
              btn_d[5] = sh_ext_q[0];
              select_d = sh_ext_q[3];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // TH is low during the odd steps only
    case (state_d)
      S_STEP1, S_STEP3, S_STEP5, S_STEP7: md_select_d = 1'b0;
      default:                            md_select_d = 1'b1;
    endcase
  end

  assign pad.md_select   = md_select_q;
  assign pad.up          = dir_q[0];
  assign pad.down        = dir_q[1];
  assign pad.left        = dir_q[2];
  assign pad.right       = dir_q[3];
  assign pad.i           = btn_q[0];
  assign pad.ii          = btn_q[1];
  assign pad.iii         = btn_q[2];
  assign pad.iv          = btn_q[3];
  assign pad.v           = btn_q[4];
  assign pad.vi          = btn_q[5];
  assign pad.select      = select_q;
  assign pad.start       = start_q;
  assign pad.pad_present = pad_present_q;
  assign pad.six_button  = six_button_q;
  assign pad.frame_done  = frame_done_q;

endmodule

// File: tb/tb_md_pad_scanner.sv
// Bench for md_pad_scanner: behavioural pad plus frame-level reference model,
// compared every cycle, with literal expectations at the end of each scenario.
module tb_md_pad_scanner;
  localparam int unsigned STEP  = 4;
  localparam int unsigned IDLE  = 16;
  localparam int unsigned FRAME = 8 * STEP + IDLE;

  // Button indices into the "pressed" vector
  localparam int BU = 0, BD = 1, BL = 2, BR = 3, BA = 4, BB = 5, BC = 6, BST = 7;
  localparam int BX = 8, BY = 9, BZ = 10, BM = 11;
  localparam logic [13:0] RST_OUT = 14'h0FFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  md_pad_if pad_if ();

  md_pad_scanner #(.STEP_CYCLES(STEP), .IDLE_CYCLES(IDLE)) dut (
    .system_clock(clk),
    .reset_n     (rst_n),
    .pad         (pad_if)
  );

  always #5 clk = ~clk;

  // Pad model: kind 0 = unplugged, 3 = 3-button, 6 = 6-button
  int          kind    = 0;
  logic [11:0] pressed = '0;
  int          lows    = 0;
  int          hi_run  = 0;
  logic        sel_prev = 1'b1;

  always @(negedge clk) begin
    if (pad_if.md_select) begin
      hi_run <= hi_run + 1;
      if (hi_run >= 8) lows <= 0;
    end else begin
      hi_run <= 0;
      if (sel_prev) lows <= lows + 1;
    end
    sel_prev <= pad_if.md_select;
  end

  function automatic logic [5:0] pad_pins(int k, logic [11:0] pr, logic sel, int nl);
    logic [11:0] n;
    n = ~pr;
    if (k == 0) return 6'h3F;
    if (sel) begin
      if (k == 6 && nl == 3) return {n[BC], n[BB], n[BM], n[BX], n[BY], n[BZ]};
      return {n[BC], n[BB], n[BR], n[BL], n[BD], n[BU]};
    end
    if (k == 6 && nl == 3) return {n[BST], n[BA], 4'b0000};
    if (k == 6 && nl == 4) return {n[BST], n[BA], 4'b1111};
    return {n[BST], n[BA], 2'b00, n[BD], n[BU]};
  endfunction

  assign pad_if.md_d = pad_pins(kind, pressed, pad_if.md_select, lows);

  // Cycles since reset release
  int t;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  function automatic logic [13:0] dut_out();
    return {pad_if.pad_present, pad_if.six_button, pad_if.up, pad_if.down,
            pad_if.left, pad_if.right, pad_if.i, pad_if.ii, pad_if.iii,
            pad_if.iv, pad_if.v, pad_if.vi, pad_if.select, pad_if.start};
  endfunction

  // What the pad looked like at each sampled phase of the current frame
  int          k0 = 0, k1 = 0, k5 = 0, k6 = 0;
  logic [11:0] s0 = '0, s1 = '0, s6 = '0;
  logic [13:0] exp_out = RST_OUT;

  function automatic logic [13:0] frame_result(int a0, int a1, int a5, int a6,
                                               logic [11:0] p0, logic [11:0] p1, logic [11:0] p6);
    logic [13:0] r;
    logic        present, six;
    r       = RST_OUT;
    present = (a1 != 0);
    six     = (a5 == 6);
    r[13]   = present;
    r[12]   = present && six;
    if (present) begin
      r[11] = !(a0 != 0 && p0[BU]);
      r[10] = !(a0 != 0 && p0[BD]);
      r[9]  = !(a0 != 0 && p0[BL]);
      r[8]  = !(a0 != 0 && p0[BR]);
      r[7]  = !(a0 != 0 && p0[BC]);
      r[6]  = !(a0 != 0 && p0[BB]);
      r[5]  = !p1[BA];
      r[0]  = !p1[BST];
      if (six) begin
        r[4] = !(a6 == 6 && p6[BX]);
        r[3] = !(a6 == 6 && p6[BY]);
        r[2] = !(a6 == 6 && p6[BZ]);
        r[1] = !(a6 == 6 && p6[BM]);
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin : compare
    int          p;
    logic [13:0] exp_now;
    logic        exp_sel, exp_fd;
    p       = t % FRAME;
    exp_now = exp_out;
    exp_sel = 1'b1;
    exp_fd  = 1'b0;
    if (!rst_n) begin
      exp_now = RST_OUT;
    end else begin
      if (p == IDLE + 0 * STEP + STEP - 1) begin k0 <= kind; s0 <= pressed; end
      if (p == IDLE + 1 * STEP + STEP - 1) begin k1 <= kind; s1 <= pressed; end
      if (p == IDLE + 5 * STEP + STEP - 1) k5 <= kind;
      if (p == IDLE + 6 * STEP + STEP - 1) begin k6 <= kind; s6 <= pressed; end
      if (p == 0 && t >= FRAME) exp_now = frame_result(k0, k1, k5, k6, s0, s1, s6);
      exp_sel = (p < IDLE) || ((((p - IDLE) / STEP) % 2) == 0);
      exp_fd  = (p == 0 && t >= FRAME);
    end
    exp_out <= exp_now;
    total = total + 3;
    if (pad_if.md_select !== exp_sel) begin
      bad = bad + 1;
      $display("FAIL md_select t=%0d: got %b want %b", t, pad_if.md_select, exp_sel);
    end
    if (pad_if.frame_done !== exp_fd) begin
      bad = bad + 1;
      $display("FAIL frame_done t=%0d: got %b want %b", t, pad_if.frame_done, exp_fd);
    end
    if (dut_out() !== exp_now) begin
      bad = bad + 1;
      $display("FAIL outputs t=%0d: got %h want %h", t, dut_out(), exp_now);
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic wait_frame(output int at);
    at = -1;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (pad_if.frame_done === 1'b1) begin
        at = t;
        break;
      end
    end
    if (at < 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL wait_frame: got no frame_done want one within %0d cycles", 3 * FRAME);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ta, tb2, tc;
    repeat (3) @(negedge clk);
    check("reset_outputs", 16'(dut_out()), 16'(RST_OUT));
    check("reset_select", 16'(pad_if.md_select), 16'd1);
    #2 rst_n = 1'b1;

    // No pad
    wait_frame(ta);
    check("first_frame_time", 16'(ta), 16'd48);
    check("nopad_outputs", 16'(dut_out()), 16'h0FFF);

    // 6-button, A + Z
    kind = 6; pressed = '0; pressed[BA] = 1'b1; pressed[BZ] = 1'b1;
    wait_frame(ta);
    check("six_a_z", 16'(dut_out()), 16'h3FDB);

    // 3-button, Start + C
    kind = 3; pressed = '0; pressed[BST] = 1'b1; pressed[BC] = 1'b1;
    wait_frame(ta);
    check("three_start_c", 16'(dut_out()), 16'h2F7E);

    // 6-button, up + left + Mode, then change buttons mid-frame
    kind = 6; pressed = '0; pressed[BU] = 1'b1; pressed[BL] = 1'b1; pressed[BM] = 1'b1;
    wait_frame(ta);
    check("six_up_left_mode", 16'(dut_out()), 16'h35FD);
    repeat (30) @(negedge clk);
    pressed = '0; pressed[BB] = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_mid_frame", 16'(dut_out()), 16'h35FD);
    wait_frame(ta);
    check("split_frame", 16'(dut_out()), 16'h35FF);
    wait_frame(ta);
    check("six_b", 16'(dut_out()), 16'h3FBF);

    // Unplug during STEP3
    pressed = '0; pressed[BX] = 1'b1; pressed[BR] = 1'b1;
    wait_frame(ta);
    check("six_x_right", 16'(dut_out()), 16'h3EEF);
    repeat (28) @(negedge clk);
    kind = 0;
    wait_frame(tb2);
    check("unplug_frame", 16'(dut_out()), 16'h2EFF);
    check("period_a", 16'(tb2 - ta), 16'd48);
    wait_frame(tc);
    check("unplugged", 16'(dut_out()), 16'h0FFF);
    check("period_b", 16'(tc - tb2), 16'd48);

    // Reset during STEP6
    kind = 6; pressed = '0; pressed[BA] = 1'b1;
    wait_frame(ta);
    check("six_a", 16'(dut_out()), 16'h3FDF);
    repeat (42) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 16'(dut_out()), 16'h0FFF);
    check("async_reset_select", 16'(pad_if.md_select), 16'd1);
    check("async_reset_done", 16'(pad_if.frame_done), 16'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_frame(ta);
    check("restart_time", 16'(ta), 16'd48);
    check("restart_outputs", 16'(dut_out()), 16'h3FDF);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
